fc_seq: RTL and testbench
=========================

# fc_seq

Sequential, parametrised fully-connected classifier layer for the BNN datapath. It takes a binary activation vector, with bit=1 meaning +1 and bit=0 meaning −1. Signed Q8.8 weights stream from an external weight memory, PAR words per cycle. The block accumulates one output class at a time, saturates each score to weight width and reports the argmax class. It replaces the fully-combinational final layer so that large IC·OC fits timing and area.

## Interface
- IC, 288: input channels; IC % PAR == 0, else elaboration error.
- OC, 10: output classes.
- WW, 16: weight/score width (Q8.8 at 16).
- PAR, 8: weights consumed per cycle.
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- start  in  1  request; accepted only when busy=0.
- in_vec  in  IC  activation bits; sampled on the start-accept cycle only.
- busy  out  1  high from the cycle after accept until return to IDLE.
- done  out  1  one-cycle pulse when results are written.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  clog2(OC·IC/PAR)  word address; word = PAR weights; lane j holds weight of input k·PAR+j.
- w_data  in  PAR·WW  read data, valid exactly 1 cycle after w_rd_en.
- scores  out  OC×WW signed  saturated per-class sums.
- class_idx  out  clog2(OC)  argmax of scores.
- out_valid  out  1  scores/class_idx valid.

## Operation
- FSM states are IDLE, RUN and DRAIN.
- IDLE + start: latch in_vec, clear accumulator/max, set out_valid=0, go to RUN.
- RUN: issue one read per cycle, addresses 0..N−1 with N=OC·IC/PAR, oc-major. After the read at N−1, go to DRAIN.
- DRAIN: consume the final word, then go to IDLE and assert done for one cycle.
- Lane term: sign-extend w to AW=WW+clog2(IC)+1, then take in_bit ? w : −w. Negating −2^(WW−1) gives +2^(WW−1) with no wrap.
- Accumulate the PAR terms of each word into an AW-bit accumulator.
- On the last word of class oc: saturate the accumulator to [−2^(WW−1), 2^(WW−1)−1] and write scores[oc]. Clear the accumulator for oc+1.
- Argmax runs on the saturated values. A class replaces the current max only if strictly greater, so ties resolve to the lowest index.
- start while busy=1 is ignored.
- start on the done cycle (FSM in IDLE) is accepted, which allows back-to-back runs; out_valid drops the next cycle.
- scores, class_idx and out_valid hold until the next accept or reset.

## Timing
- Reset values: busy=0, done=0, w_rd_en=0, w_addr=0, scores all 0, class_idx=0, out_valid=0, FSM=IDLE.
- Accept at cycle 0.
- w_rd_en=1 on cycles 1..N, with w_addr=t−1.
- Data is accumulated on cycles 2..N+1.
- scores[OC−1] and class_idx are registered at the end of cycle N+1.
- done=1 and out_valid=1 from cycle N+2. Defaults: N=360, done at cycle 362.
- Throughput: one run per N+2 cycles.
- rst_n low at any cycle, including mid-RUN or DRAIN, returns to reset values on the next edge. In-flight w_data is discarded.
- All outputs are registered.

## Structure
- Package fc_pkg holds:
  - function sat_to_ww;
  - localparams N and AW (derived);
  - state enum typedef {IDLE, RUN, DRAIN}.
- Sub-module fc_lane_sum: combinational PAR-lane conditional-negate plus adder tree, PAR·WW bits and PAR activation bits in, AW bits out.
- The top level holds the FSM, counters (word, oc), accumulator, score registers and argmax.

## Test plan
Tests use IC=16, OC=4, PAR=4, WW=16, giving N=16.
- Max positive sum: all weights 0x0100, in_vec all ones, start at cycle 0 -> scores all 0x1000, class_idx=0 (tie), done exactly at cycle 18, busy high cycles 1–17.
- Positive and negative saturation: all weights 0x7FFF, in_vec all ones -> scores 0x7FFF. Same weights with in_vec all zeros -> 0x8000.
- Most-negative weight: all weights 0x8000, in_vec all zeros -> each term +32768, scores 0x7FFF (no wrap). in_vec alternating 1010… -> scores 0x0000.
- Argmax: class c weights = c·0x0040, in_vec all ones -> scores 0x0000/0x0400/0x0800/0x0C00, class_idx=3. With classes 1 and 3 equal and highest -> class_idx=1.
- Reset: rst_n low at cycle 6 of a run -> next cycle all outputs at reset values, w_rd_en=0. A fresh run then gives correct results.
- Handshake:
  - start pulses during RUN -> no effect, done still at cycle 18;
  - start on the done cycle -> accepted, out_valid=0 next cycle, second done at 18 cycles later.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types, default geometry and score saturation for the sequential FC classifier.
// The derived N/AW here describe the default geometry; fc_seq re-derives them from its own parameters.
package fc_pkg;

    localparam int FC_IC  = 288;
    localparam int FC_OC  = 10;
    localparam int FC_WW  = 16;
    localparam int FC_PAR = 8;

    localparam int N  = FC_OC * FC_IC / FC_PAR;
    localparam int AW = FC_WW + $clog2(FC_IC) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Clamp a wide signed sum into the signed range of a ww-bit score.
    function automatic logic signed [63:0] sat_to_ww(input logic signed [63:0] v, input int ww);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (ww - 1);
        if (v > lim - 64'sd1)
            return lim - 64'sd1;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

endpackage

// File: rtl/fc_lane_sum.sv
// Combinational sum of PAR weight lanes, each conditionally negated by its activation bit.
// Lanes are sign-extended to AW first, so negating the most-negative weight cannot wrap.
module fc_lane_sum #(
    parameter int PAR = 8,
    parameter int WW  = 16,
    parameter int AW  = 26
) (
    input  logic [PAR*WW-1:0]   w,
    input  logic [PAR-1:0]      act,
    output logic signed [AW-1:0] sum
);

    logic signed [AW-1:0] term;

    always_comb begin
        sum  = '0;
        term = '0;
        for (int j = 0; j < PAR; j++) begin
            term = {{(AW-WW){w[j*WW+WW-1]}}, w[j*WW +: WW]};
            sum  = sum + (act[j] ? term : -term);
        end
    end

endmodule

// File: rtl/fc_seq.sv
// Sequential fully-connected classifier: streams PAR weights per cycle, one class at a time,
// saturates each class score to WW bits and keeps a running strict-greater argmax.
module fc_seq
    import fc_pkg::*;
#(
    parameter int IC  = FC_IC,
    parameter int OC  = FC_OC,
    parameter int WW  = FC_WW,
    parameter int PAR = FC_PAR
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [IC-1:0]                  in_vec,
    output logic                           busy,
    output logic                           done,
    output logic                           w_rd_en,
    output logic [$clog2(OC*IC/PAR)-1:0]   w_addr,
    input  logic [PAR*WW-1:0]              w_data,
    output logic [OC*WW-1:0]               scores,
    output logic [$clog2(OC)-1:0]          class_idx,
    output logic                           out_valid
);

    localparam int NW  = OC * IC / PAR;
    localparam int ACW = WW + $clog2(IC) + 1;
    localparam int AB  = $clog2(NW);
    localparam int KW  = IC / PAR;
    localparam int KB  = (KW > 1) ? $clog2(KW) : 1;
    localparam int CB  = $clog2(OC);

    if (IC % PAR != 0) begin : g_bad_geometry
        $error("fc_seq: IC must be a multiple of PAR");
    end

    state_t                state;
    logic [IC-1:0]         act;
    logic                  dvld;
    logic [KB-1:0]         kcnt;
    logic [CB-1:0]         occ;
    logic signed [ACW-1:0] acc;
    logic signed [ACW-1:0] lane_sum;
    logic signed [ACW-1:0] acc_next;
    logic signed [WW-1:0]  best;
    logic signed [WW-1:0]  sat;
    logic [PAR-1:0]        lane_act;

    // kcnt tracks the word currently arriving on w_data, one cycle behind the address.
    assign lane_act = act[int'(kcnt)*PAR +: PAR];
    assign acc_next = acc + lane_sum;
    assign sat      = WW'(sat_to_ww(64'(acc_next), WW));

    fc_lane_sum #(
        .PAR (PAR),
        .WW  (WW),
        .AW  (ACW)
    ) u_lane_sum (
        .w   (w_data),
        .act (lane_act),
        .sum (lane_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            act       <= '0;
            dvld      <= 1'b0;
            kcnt      <= '0;
            occ       <= '0;
            acc       <= '0;
            best      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            scores    <= '0;
            class_idx <= '0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            dvld <= w_rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        act       <= in_vec;
                        acc       <= '0;
                        best      <= '0;
                        kcnt      <= '0;
                        occ       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b1;
                        w_rd_en   <= 1'b1;
                        w_addr    <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_addr == AB'(NW - 1)) begin
                        w_rd_en <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        w_addr <= w_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (dvld) begin
                if (kcnt == KB'(KW - 1)) begin
                    kcnt <= '0;
                    acc  <= '0;
                    occ  <= occ + 1'b1;
                    scores[int'(occ)*WW +: WW] <= sat;
                    // First class seeds the max; later ones must be strictly greater.
                    if (occ == '0 || sat > best) begin
                        best      <= sat;
                        class_idx <= occ;
                    end
                end else begin
                    kcnt <= kcnt + 1'b1;
                    acc  <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_seq.sv
// Bench for fc_seq at IC=16, OC=4, PAR=4, WW=16: directed cases plus randomized runs
// checked against a plain-arithmetic model of the classifier.
module tb_fc_seq;

    localparam int IC  = 16;
    localparam int OC  = 4;
    localparam int PAR = 4;
    localparam int WW  = 16;
    localparam int NW  = OC * IC / PAR;
    localparam int KW  = IC / PAR;
    localparam int AB  = $clog2(NW);
    localparam int CB  = $clog2(OC);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [IC-1:0]        in_vec;
    logic                 busy;
    logic                 done;
    logic                 w_rd_en;
    logic [AB-1:0]        w_addr;
    logic [PAR*WW-1:0]    w_data;
    logic [OC*WW-1:0]     scores;
    logic [CB-1:0]        class_idx;
    logic                 out_valid;

    int checks = 0;
    int errors = 0;

    int                   wt [OC][IC];
    logic [PAR*WW-1:0]    mem [NW];
    int                   exp_sc [OC];
    int                   exp_idx;

    fc_seq #(.IC(IC), .OC(OC), .WW(WW), .PAR(PAR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_vec    (in_vec),
        .busy      (busy),
        .done      (done),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .scores    (scores),
        .class_idx (class_idx),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Weight memory with one-cycle read latency; junk on idle cycles.
    always @(posedge clk)
        w_data <= w_rd_en ? mem[w_addr] : {$urandom, $urandom};

    function automatic int score_of(input int c);
        return int'($signed(scores[c*WW +: WW]));
    endfunction

    task automatic load_weights();
        for (int c = 0; c < OC; c++)
            for (int i = 0; i < IC; i++)
                mem[c*KW + i/PAR][(i%PAR)*WW +: WW] = 16'(wt[c][i]);
    endtask

    task automatic set_all(input int val);
        for (int c = 0; c < OC; c++)
            for (int i = 0; i < IC; i++)
                wt[c][i] = val;
        load_weights();
    endtask

    task automatic set_per_class(input int v0, input int v1, input int v2, input int v3);
        int v [OC];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int c = 0; c < OC; c++)
            for (int i = 0; i < IC; i++)
                wt[c][i] = v[c];
        load_weights();
    endtask

    // Reference: dot product with +/-1 activations, clamp, first strict maximum.
    task automatic compute_model(input logic [IC-1:0] v);
        for (int c = 0; c < OC; c++) begin
            longint s = 0;
            for (int i = 0; i < IC; i++)
                s += v[i] ? wt[c][i] : -wt[c][i];
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp_sc[c] = int'(s);
        end
        exp_idx = 0;
        for (int c = 1; c < OC; c++)
            if (exp_sc[c] > exp_sc[exp_idx]) exp_idx = c;
    endtask

    // Start a run and follow it to done; returns done cycle (accept = cycle 0) and
    // counts of cycles where busy or the read strobe/address deviated from the schedule.
    task automatic run_once(input logic [IC-1:0] v, input logic [63:0] pulses,
                            output int done_t, output int busy_bad, output int rd_bad);
        done_t = -1; busy_bad = 0; rd_bad = 0;
        in_vec = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            start = pulses[t];
            @(negedge clk);
            if (busy !== (t <= NW + 1)) busy_bad++;
            if (w_rd_en !== (t <= NW) || (t <= NW && w_addr !== AB'(t - 1))) rd_bad++;
            if (done === 1'b1) begin
                done_t = t;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset done got %b exp 0", done); end
        checks++; if (w_rd_en !== 1'b0)   begin errors++; $display("FAIL reset w_rd_en got %b exp 0", w_rd_en); end
        checks++; if (w_addr !== '0)      begin errors++; $display("FAIL reset w_addr got %h exp 0", w_addr); end
        checks++; if (scores !== '0)      begin errors++; $display("FAIL reset scores got %h exp 0", scores); end
        checks++; if (class_idx !== '0)   begin errors++; $display("FAIL reset class_idx got %0d exp 0", class_idx); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_max_pos();
        int dt, bb, rb;
        set_all(32'h0100);
        run_once('1, 64'd0, dt, bb, rb);
        checks++; if (dt !== 18) begin errors++; $display("FAIL maxpos done_cycle got %0d exp 18", dt); end
        checks++; if (bb !== 0)  begin errors++; $display("FAIL maxpos busy_window bad_cycles %0d exp 0", bb); end
        checks++; if (rb !== 0)  begin errors++; $display("FAIL maxpos read_schedule bad_cycles %0d exp 0", rb); end
        for (int c = 0; c < OC; c++) begin
            checks++;
            if (score_of(c) !== 32'h1000) begin errors++; $display("FAIL maxpos score[%0d] got %h exp 1000", c, score_of(c)); end
        end
        checks++; if (class_idx !== 2'd0) begin errors++; $display("FAIL maxpos class_idx got %0d exp 0", class_idx); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL maxpos out_valid got %b exp 1", out_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL maxpos after_done done=%b busy=%b ov=%b exp 0 0 1", done, busy, out_valid);
        end
    endtask

    task automatic test_saturation();
        int dt, bb, rb;
        set_all(32'h7FFF);
        run_once('1, 64'd0, dt, bb, rb);
        for (int c = 0; c < OC; c++) begin
            checks++;
            if (score_of(c) !== 32767) begin errors++; $display("FAIL sat_pos score[%0d] got %0d exp 32767", c, score_of(c)); end
        end
        run_once('0, 64'd0, dt, bb, rb);
        for (int c = 0; c < OC; c++) begin
            checks++;
            if (score_of(c) !== -32768) begin errors++; $display("FAIL sat_neg score[%0d] got %0d exp -32768", c, score_of(c)); end
        end
        checks++; if (dt !== 18) begin errors++; $display("FAIL sat_neg done_cycle got %0d exp 18", dt); end
    endtask

    task automatic test_most_negative();
        int dt, bb, rb;
        set_all(-32768);
        run_once('0, 64'd0, dt, bb, rb);
        for (int c = 0; c < OC; c++) begin
            checks++;
            if (score_of(c) !== 32767) begin errors++; $display("FAIL minw_neg score[%0d] got %0d exp 32767", c, score_of(c)); end
        end
        run_once(16'hAAAA, 64'd0, dt, bb, rb);
        for (int c = 0; c < OC; c++) begin
            checks++;
            if (score_of(c) !== 0) begin errors++; $display("FAIL minw_alt score[%0d] got %0d exp 0", c, score_of(c)); end
        end
    endtask

    task automatic test_argmax();
        int dt, bb, rb;
        int ev [OC];
        set_per_class(0, 32'h40, 32'h80, 32'hC0);
        run_once('1, 64'd0, dt, bb, rb);
        ev[0] = 0; ev[1] = 32'h400; ev[2] = 32'h800; ev[3] = 32'hC00;
        for (int c = 0; c < OC; c++) begin
            checks++;
            if (score_of(c) !== ev[c]) begin errors++; $display("FAIL argmax score[%0d] got %h exp %h", c, score_of(c), ev[c]); end
        end
        checks++; if (class_idx !== 2'd3) begin errors++; $display("FAIL argmax class_idx got %0d exp 3", class_idx); end
        set_per_class(0, 32'h40, 0, 32'h40);
        run_once('1, 64'd0, dt, bb, rb);
        checks++; if (class_idx !== 2'd1) begin errors++; $display("FAIL argmax_tie class_idx got %0d exp 1", class_idx); end
    endtask

    task automatic test_reset_mid_run();
        int dt, bb, rb;
        set_per_class(0, 32'h40, 32'h80, 32'hC0);
        in_vec = '1;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({busy, done, w_rd_en, out_valid} !== 4'b0000) begin
            errors++; $display("FAIL midreset flags busy/done/rd/ov got %b%b%b%b exp 0000", busy, done, w_rd_en, out_valid);
        end
        checks++; if (w_addr !== '0 || class_idx !== '0 || scores !== '0) begin
            errors++; $display("FAIL midreset data addr=%h idx=%0d scores=%h exp all 0", w_addr, class_idx, scores);
        end
        rst_n = 1'b1;
        set_per_class(32'h20, 32'hFF00, 32'h10, 32'h0);
        run_once('1, 64'd0, dt, bb, rb);
        checks++; if (dt !== 18) begin errors++; $display("FAIL midreset_rerun done_cycle got %0d exp 18", dt); end
        checks++; if (score_of(0) !== 32'h200 || score_of(1) !== -4096 || score_of(2) !== 32'h100 || score_of(3) !== 0) begin
            errors++; $display("FAIL midreset_rerun scores got %h exp 0000_0100_f000_0200", scores);
        end
        checks++; if (class_idx !== 2'd0) begin errors++; $display("FAIL midreset_rerun class_idx got %0d exp 0", class_idx); end
    endtask

    task automatic test_start_during_run();
        int dt, bb, rb;
        logic [63:0] p;
        p = '0;
        p[3] = 1'b1; p[8] = 1'b1; p[15] = 1'b1; p[17] = 1'b1;
        set_per_class(0, 32'h40, 32'h80, 32'hC0);
        run_once('1, p, dt, bb, rb);
        checks++; if (dt !== 18) begin errors++; $display("FAIL busy_start done_cycle got %0d exp 18", dt); end
        checks++; if (bb !== 0 || rb !== 0) begin errors++; $display("FAIL busy_start schedule busy_bad=%0d rd_bad=%0d exp 0 0", bb, rb); end
        checks++; if (score_of(3) !== 32'hC00 || class_idx !== 2'd3) begin
            errors++; $display("FAIL busy_start result score3=%h idx=%0d exp c00 3", score_of(3), class_idx);
        end
    endtask

    task automatic test_back_to_back();
        int dt, bb, rb, dt2;
        set_per_class(0, 32'h40, 32'h80, 32'hC0);
        run_once('1, 64'd0, dt, bb, rb);
        in_vec = '0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b accept ov=%b busy=%b exp 0 1", out_valid, busy);
        end
        dt2 = -1;
        for (int t = 2; t <= 60; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin dt2 = t; break; end
        end
        checks++; if (dt2 !== 18) begin errors++; $display("FAIL b2b second_done got %0d exp 18", dt2); end
        checks++; if (score_of(0) !== 0 || score_of(1) !== -1024 || score_of(2) !== -2048 || score_of(3) !== -3072) begin
            errors++; $display("FAIL b2b scores got %h exp f400_f800_fc00_0000", scores);
        end
        checks++; if (class_idx !== 2'd0) begin errors++; $display("FAIL b2b class_idx got %0d exp 0", class_idx); end
    endtask

    task automatic test_random();
        int dt, bb, rb;
        logic [IC-1:0] v;
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < OC; c++)
                for (int i = 0; i < IC; i++)
                    wt[c][i] = (it % 2 == 0) ? int'($urandom_range(0, 1023)) - 512
                                             : int'($signed(16'($urandom)));
            load_weights();
            v = 16'($urandom);
            compute_model(v);
            run_once(v, 64'd0, dt, bb, rb);
            checks++; if (dt !== 18 || bb !== 0 || rb !== 0) begin
                errors++; $display("FAIL random[%0d] timing done=%0d busy_bad=%0d rd_bad=%0d exp 18 0 0", it, dt, bb, rb);
            end
            for (int c = 0; c < OC; c++) begin
                checks++;
                if (score_of(c) !== exp_sc[c]) begin
                    errors++; $display("FAIL random[%0d] score[%0d] got %0d exp %0d", it, c, score_of(c), exp_sc[c]);
                end
            end
            checks++; if (int'(class_idx) !== exp_idx) begin
                errors++; $display("FAIL random[%0d] class_idx got %0d exp %0d", it, class_idx, exp_idx);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        in_vec = '0;
        set_all(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_max_pos();
        test_saturation();
        test_most_negative();
        test_argmax();
        test_reset_mid_run();
        test_start_during_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
